// File: rtl/r_bank_pkg.sv
// r_bank_pkg: write-port operation codes and op-field width shared by the register bank.
package r_bank_pkg;
  localparam int OP_W = 3;
  typedef enum logic [OP_W-1:0] {
    OP_HOLD = 3'b000,
    OP_LOAD = 3'b001,
    OP_INC  = 3'b010,
    OP_DEC  = 3'b011,
    OP_SHL  = 3'b100,
    OP_SHR  = 3'b101,
    OP_ROL  = 3'b110,
    OP_CLR  = 3'b111
  } op_e;
endpackage

// File: rtl/r_op_unit.sv
// r_op_unit: combinational in-place op (value, s, op) -> (next_value, carry); carry is carry/borrow/shifted-out bit.
module r_op_unit
  import r_bank_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] value,
  input  logic [WIDTH-1:0] s,
  input  logic [OP_W-1:0]  op,
  output logic [WIDTH-1:0] next_value,
  output logic             carry
);
  always_comb begin
    {carry, next_value} = {1'b0, value};
    case (op)
      OP_LOAD: {carry, next_value} = {1'b0, s};
      OP_INC:  {carry, next_value} = {1'b0, value} + (WIDTH+1)'(1);
      OP_DEC:  {carry, next_value} = {1'b0, value} - (WIDTH+1)'(1);
      OP_SHL:  {carry, next_value} = {value, 1'b0};
      OP_SHR:  {carry, next_value} = {value[0], 1'b0, value[WIDTH-1:1]};
      OP_ROL:  {carry, next_value} = {value[WIDTH-1], value[WIDTH-2:0], value[WIDTH-1]};
      OP_CLR:  {carry, next_value} = '0;
      default: ;
    endcase
  end
endmodule

// File: rtl/r_reg_bank.sv
// r_reg_bank: DEPTH x WIDTH register bank; one op-applying write port, two forwarded registered read ports, Z/C flags.
// Ports: clk, rst (sync high), WR_EN/WR_ADDR/OP/S write port, RA_ADDR/RB_ADDR -> RA/RB, FLAG_Z/FLAG_C.
module r_reg_bank
  import r_bank_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int DEPTH = 4,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             WR_EN,
  input  logic [AW-1:0]    WR_ADDR,
  input  logic [OP_W-1:0]  OP,
  input  logic [WIDTH-1:0] S,
  input  logic [AW-1:0]    RA_ADDR,
  input  logic [AW-1:0]    RB_ADDR,
  output logic [WIDTH-1:0] RA,
  output logic [WIDTH-1:0] RB,
  output logic             FLAG_Z,
  output logic             FLAG_C
);
  localparam logic [AW:0] LIM = (AW+1)'(DEPTH);
  logic [WIDTH-1:0] regs [DEPTH];
  logic [WIDTH-1:0] cur, nxt, ra_d, rb_d;
  logic             wr_ok, carry;
  assign wr_ok = WR_EN && ({1'b0, WR_ADDR} < LIM);
  assign cur   = wr_ok ? regs[WR_ADDR] : '0;
  r_op_unit #(.WIDTH(WIDTH)) u_op (
    .value(cur), .s(S), .op(OP), .next_value(nxt), .carry(carry)
  );
  // Reads of an address being written this cycle see the post-op value.
  assign ra_d = ({1'b0, RA_ADDR} < LIM) ? ((wr_ok && RA_ADDR == WR_ADDR) ? nxt : regs[RA_ADDR]) : '0;
  assign rb_d = ({1'b0, RB_ADDR} < LIM) ? ((wr_ok && RB_ADDR == WR_ADDR) ? nxt : regs[RB_ADDR]) : '0;
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) regs[i] <= '0;
      RA     <= '0;
      RB     <= '0;
      FLAG_Z <= 1'b0;
      FLAG_C <= 1'b0;
    end else begin
      if (wr_ok) begin
        regs[WR_ADDR] <= nxt;
        FLAG_Z        <= (nxt == '0);
        FLAG_C        <= carry;
      end
      RA <= ra_d;
      RB <= rb_d;
    end
  end
endmodule

// File: tb/tb_r_reg_bank.sv
// tb_r_reg_bank: directed checks of r_reg_bank (DEPTH=4 instance plus DEPTH=3 instance for out-of-range addressing).
module tb_r_reg_bank;
  import r_bank_pkg::*;
  logic       clk = 0;
  logic       rst;
  logic       wr_en, wr_en3;
  logic [1:0] wr_addr, ra_addr, rb_addr, wr_addr3, ra_addr3, rb_addr3;
  logic [2:0] op, op3;
  logic [3:0] s, s3, ra, rb, ra3, rb3;
  logic       fz, fc, fz3, fc3;
  int n_assert = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  r_reg_bank #(.WIDTH(4), .DEPTH(4)) dut (
    .clk(clk), .rst(rst), .WR_EN(wr_en), .WR_ADDR(wr_addr), .OP(op), .S(s),
    .RA_ADDR(ra_addr), .RB_ADDR(rb_addr), .RA(ra), .RB(rb), .FLAG_Z(fz), .FLAG_C(fc)
  );

  r_reg_bank #(.WIDTH(4), .DEPTH(3)) dut3 (
    .clk(clk), .rst(rst), .WR_EN(wr_en3), .WR_ADDR(wr_addr3), .OP(op3), .S(s3),
    .RA_ADDR(ra_addr3), .RB_ADDR(rb_addr3), .RA(ra3), .RB(rb3), .FLAG_Z(fz3), .FLAG_C(fc3)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [1:0] a, input logic [2:0] o, input logic [3:0] d);
    wr_en = 1; wr_addr = a; op = o; s = d;
  endtask

  initial begin
    rst = 1; wr_en = 0; wr_addr = 0; op = OP_HOLD; s = 0; ra_addr = 0; rb_addr = 0;
    wr_en3 = 0; wr_addr3 = 0; op3 = OP_HOLD; s3 = 0; ra_addr3 = 0; rb_addr3 = 0;
    step(); step();
    check("rst_ra", ra, 0);
    check("rst_rb", rb, 0);
    check("rst_z", fz, 0);
    check("rst_c", fc, 0);
    // reset wins over a simultaneous LOAD
    wr(0, OP_LOAD, 4'hA);
    step();
    rst = 0; wr_en = 0;
    step();
    check("rst_over_load", ra, 0);
    for (int a = 1; a < 4; a++) begin
      ra_addr = 2'(a); rb_addr = 2'(a);
      step();
      check("rst_read_a", ra, 0);
      check("rst_read_b", rb, 0);
    end
    // r1: LOAD F, INC wraps, DEC borrows
    wr(1, OP_LOAD, 4'hF); ra_addr = 1;
    step();
    check("load_f", ra, 4'hF);
    check("load_z", fz, 0);
    check("load_c", fc, 0);
    op = OP_INC;
    step();
    check("inc_wrap", ra, 4'h0);
    check("inc_z", fz, 1);
    check("inc_c", fc, 1);
    op = OP_DEC;
    step();
    check("dec_borrow", ra, 4'hF);
    check("dec_z", fz, 0);
    check("dec_c", fc, 1);
    // r2: shifts and rotate
    wr(2, OP_LOAD, 4'h9); ra_addr = 2;
    step();
    op = OP_SHL;
    step();
    check("shl_val", ra, 4'h2);
    check("shl_c", fc, 1);
    op = OP_SHR;
    step();
    check("shr_val", ra, 4'h1);
    check("shr_c", fc, 0);
    op = OP_LOAD; s = 4'h9;
    step();
    op = OP_ROL;
    step();
    check("rol_val", ra, 4'h3);
    check("rol_c", fc, 1);
    // flags hold with no write
    wr_en = 0;
    step();
    check("hold_c", fc, 1);
    check("hold_z", fz, 0);
    // HOLD with write enable: rewrites value, C cleared
    wr(2, OP_HOLD, 4'h0);
    step();
    check("hold_op_val", ra, 4'h3);
    check("hold_op_c", fc, 0);
    // forwarding on port A while port B reads r0
    wr(3, OP_LOAD, 4'h5); ra_addr = 3; rb_addr = 0;
    step();
    check("fwd_ra", ra, 4'h5);
    check("fwd_rb", rb, 4'h0);
    // back-to-back INC on r0, both ports on same address
    wr(0, OP_INC, 4'h0); ra_addr = 0; rb_addr = 0;
    for (int k = 1; k <= 4; k++) begin
      step();
      check("inc_seq_a", ra, 32'(k));
      check("inc_seq_b", rb, 32'(k));
      check("inc_seq_c", fc, 0);
    end
    op = OP_CLR;
    step();
    check("clr_val", ra, 0);
    check("clr_z", fz, 1);
    check("clr_c", fc, 0);
    wr_en = 0; ra_addr = 1; rb_addr = 3;
    step();
    check("r1_kept", ra, 4'hF);
    check("r3_kept", rb, 4'h5);
    // DEPTH=3 instance: out-of-range write ignored, read returns 0
    wr_en3 = 1; wr_addr3 = 2; op3 = OP_LOAD; s3 = 4'h6;
    step();
    wr_addr3 = 0; op3 = OP_DEC;
    step();
    check("d3_dec_z", fz3, 0);
    check("d3_dec_c", fc3, 1);
    wr_addr3 = 3; op3 = OP_LOAD; s3 = 4'h7; ra_addr3 = 3; rb_addr3 = 2;
    step();
    check("d3_oob_ra", ra3, 0);
    check("d3_oob_rb", rb3, 4'h6);
    check("d3_oob_z", fz3, 0);
    check("d3_oob_c", fc3, 1);
    wr_en3 = 0; rb_addr3 = 0;
    step();
    check("d3_oob_ra2", ra3, 0);
    check("d3_r0", rb3, 4'hF);
    // mid-sequence reset then first write operates on 0
    wr(1, OP_INC, 4'h0); ra_addr = 1; rst = 1;
    step();
    check("mid_rst_ra", ra, 0);
    check("mid_rst_z", fz, 0);
    check("mid_rst_c", fc, 0);
    rst = 0;
    step();
    check("post_rst_inc", ra, 4'h1);
    check("post_rst_z", fz, 0);
    wr_en = 0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule

// File: doc/r_reg_bank.md
# r_reg_bank

Parametrised bank of DEPTH general-purpose registers, each WIDTH bits, replacing the single enable-loaded R register in the simple CPU datapath. One write port applies an in-place operation to the addressed register: load, increment, decrement, shift, rotate or clear. Two registered read ports with write-forwarding feed the ALU operand buses. Zero and carry flags are registered for the control unit.

## Interface
Parameters:
- WIDTH, 4, bits per register (≥2)
- DEPTH, 4, number of registers (≥2; need not be a power of two)
- AW, $clog2(DEPTH), address width (derived; do not override)

Ports:
- clk  in  1  single clock; all state updates on rising edge
- rst  in  1  reset, synchronous, active-high
- WR_EN  in  1  apply OP to register WR_ADDR this cycle
- WR_ADDR  in  AW  target register
- OP  in  3  write operation (encoding below)
- S  in  WIDTH  load data
- RA_ADDR  in  AW  read port A address
- RB_ADDR  in  AW  read port B address
- RA  out  WIDTH  registered read data A
- RB  out  WIDTH  registered read data B
- FLAG_Z  out  1  result of last write was zero
- FLAG_C  out  1  carry/borrow/shifted-out bit of last write

## Operation
- OP encoding: 000 HOLD, 001 LOAD (S), 010 INC (+1), 011 DEC (−1), 100 SHL (0 shifted in), 101 SHR (logical, 0 shifted in), 110 ROL, 111 CLR.
- Arithmetic is modulo 2^WIDTH. C is set as follows:
  - INC: carry out (wrap all-ones→0 gives C=1).
  - DEC: borrow (0→all-ones gives C=1).
  - SHL: old MSB. SHR: old LSB. ROL: old MSB (also rotated into the LSB).
  - LOAD, CLR, HOLD: C=0.
- Z = (result == 0).
- Flags update only on cycles with WR_EN=1 and a valid WR_ADDR. Otherwise they hold.
- HOLD with WR_EN=1 rewrites the current value and updates the flags: Z from the value, C=0.
- Address ≥ DEPTH:
  - write is ignored, with no register or flag change;
  - a read returns 0.
- Read forwarding: if a read address equals WR_ADDR on a cycle with a valid write, that port captures the post-operation value.
- RA_ADDR == RB_ADDR is legal; both ports return the same data.
- Reset: all registers, RA, RB, FLAG_Z and FLAG_C go to 0. Reset overrides WR_EN on the same edge.

## Timing
- Write: operation is computed combinationally from the current register value and committed at the rising edge. The new value is visible in the array from the next cycle.
- Read: 1-cycle latency. Address presented in cycle n gives data on RA/RB after edge n.
- Flags: same edge as the write commit.
- Back-to-back writes to one address (e.g. INC every cycle) each see the previous cycle's result. No stall or bubble.
- Reset asserted mid-sequence clears everything at that edge. The first write after deassertion operates on 0.

## Structure
- Package r_bank_pkg holds:
  - OP code localparams/enum (OP_HOLD…OP_CLR);
  - the op-field width constant.
- Sub-module r_op_unit: combinational, (value, S, OP) → (next_value, carry). Instantiated once on the write port.
- Top holds:
  - the register array;
  - write decode with range check;
  - the two forwarded registered read muxes;
  - the flag registers.

## Test plan
With WIDTH=4, DEPTH=4 unless stated:
- Reset then read all addresses → RA=RB=0, FLAG_Z=0, FLAG_C=0. Reset asserted together with WR_EN LOAD 0xA → reg stays 0.
- LOAD 0xF to r1, then INC r1 → r1=0x0, Z=1, C=1. Then DEC r1 → 0xF, Z=0, C=1.
- LOAD 0x9 to r2, then SHL → 0x2, C=1. SHR → 0x1, C=0. ROL on 0x9 → 0x3, C=1.
- Forwarding: LOAD 0x5 to r3 with RA_ADDR=3 and RB_ADDR=0 on the same cycle → next cycle RA=0x5, RB=old r0.
- DEPTH=3: write LOAD 0x7 to address 3 → no change, flags hold, read of address 3 returns 0.
- Four consecutive INC on r0 from 0 → r0 reads 1,2,3,4 on successive cycles. CLR → 0, Z=1, C=0.
